// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: pattern type, glyph constants, error codes, scan states.
// Segment order is bit6=a down to bit0=g, 1 = lit.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } scan_state_e;

    localparam seg7_t SEG_0 = 7'b1111110;
    localparam seg7_t SEG_1 = 7'b0110000;
    localparam seg7_t SEG_2 = 7'b1101101;
    localparam seg7_t SEG_3 = 7'b1111001;
    localparam seg7_t SEG_4 = 7'b0110011;
    localparam seg7_t SEG_5 = 7'b1011011;
    localparam seg7_t SEG_6 = 7'b1011111;
    localparam seg7_t SEG_7 = 7'b1110000;
    localparam seg7_t SEG_8 = 7'b1111111;
    localparam seg7_t SEG_9 = 7'b1111011;
    localparam seg7_t SEG_A = 7'b1110111;
    localparam seg7_t SEG_B = 7'b0011111;
    localparam seg7_t SEG_C = 7'b1001110;
    localparam seg7_t SEG_D = 7'b0111101;
    localparam seg7_t SEG_E = 7'b1001111;
    localparam seg7_t SEG_F = 7'b1000111;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BADPAT   = 2'b01;
    localparam logic [1:0] ERR_MULTIHOT = 2'b10;

endpackage

// File: rtl/seg7_to_bin.sv
// Combinational inverse of the seven-segment encoder table; o_ok low for any pattern
// the encoder can never produce.
module seg7_to_bin
    import seg7_pkg::*;
(
    input  seg7_t      i_seg,
    output logic [3:0] o_val,
    output logic       o_ok
);

    always_comb begin
        o_val = 4'h0;
        o_ok  = 1'b1;
        case (i_seg)
            SEG_0:   o_val = 4'h0;
            SEG_1:   o_val = 4'h1;
            SEG_2:   o_val = 4'h2;
            SEG_3:   o_val = 4'h3;
            SEG_4:   o_val = 4'h4;
            SEG_5:   o_val = 4'h5;
            SEG_6:   o_val = 4'h6;
            SEG_7:   o_val = 4'h7;
            SEG_8:   o_val = 4'h8;
            SEG_9:   o_val = 4'h9;
            SEG_A:   o_val = 4'hA;
            SEG_B:   o_val = 4'hB;
            SEG_C:   o_val = 4'hC;
            SEG_D:   o_val = 4'hD;
            SEG_E:   o_val = 4'hE;
            SEG_F:   o_val = 4'hF;
            default: o_ok  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed seven-segment bus, debounces each digit dwell and keeps a decoded
// per-digit register file; capture lands STABLE_CYCLES edges after the first sample.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  seg7_t                   i_seg,
    input  logic [NUM_DIGITS-1:0]   i_dig_en,
    output logic [4*NUM_DIGITS-1:0] o_digits,
    output logic [NUM_DIGITS-1:0]   o_digit_valid,
    output logic                    o_frame_valid,
    output logic                    o_err,
    output logic [1:0]              o_err_code
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int SW    = NUM_DIGITS + 7;

    logic [SW-1:0]           s_q, s_d, p_q, p_d;
    scan_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d, dvalid_q, dvalid_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic                    frame_q, frame_d, err_q, err_d;
    logic [1:0]              err_code_q, err_code_d;

    logic [NUM_DIGITS-1:0]   s_en, p_en;
    seg7_t                   s_seg;
    logic                    en_multi, en_onehot, s_changed, capture;
    logic [CNT_W-1:0]        cnt_run;
    logic [3:0]              dec_val;
    logic                    dec_ok;

    assign s_en      = s_q[SW-1:7];
    assign s_seg     = s_q[6:0];
    assign p_en      = p_q[SW-1:7];
    assign en_multi  = (s_en & (s_en - NUM_DIGITS'(1))) != '0;
    assign en_onehot = (s_en != '0) && !en_multi;

    seg7_to_bin u_dec (
        .i_seg (s_seg),
        .o_val (dec_val),
        .o_ok  (dec_ok)
    );

    always_comb begin
        s_d        = {i_dig_en, i_seg};
        p_d        = s_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        seen_d     = seen_q;
        dvalid_d   = dvalid_q;
        digits_d   = digits_q;
        frame_d    = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        capture    = 1'b0;
        s_changed  = (s_q != p_q);
        // Only an unbroken SETTLE run extends the count; every other entry restarts at 1.
        cnt_run    = (state_q == ST_SETTLE && !s_changed) ? cnt_q + CNT_W'(1) : CNT_W'(1);

        if (!en_onehot) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (!(state_q == ST_HELD && !s_changed)) begin
            cnt_d = cnt_run;
            if (cnt_run == CNT_W'(STABLE_CYCLES)) begin
                capture = 1'b1;
                state_d = ST_HELD;
            end else begin
                state_d = ST_SETTLE;
            end
        end

        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (s_en[i]) begin
                    if (dec_ok) begin
                        digits_d[4*i +: 4] = dec_val;
                        dvalid_d[i]        = 1'b1;
                        seen_d[i]          = 1'b1;
                    end else begin
                        dvalid_d[i] = 1'b0;
                        err_d       = 1'b1;
                        err_code_d  = ERR_BADPAT;
                    end
                end
            end
            if (dec_ok && (&seen_d)) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end
        end

        // A parked multi-hot enable reports once; only a new enable value re-arms it.
        if (en_multi && (s_en != p_en)) begin
            err_d      = 1'b1;
            err_code_d = ERR_MULTIHOT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q        <= '0;
            p_q        <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            seen_q     <= '0;
            dvalid_q   <= '0;
            digits_q   <= '0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            s_q        <= s_d;
            p_q        <= p_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            dvalid_q   <= dvalid_d;
            digits_q   <= digits_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign o_digits      = digits_q;
    assign o_digit_valid = dvalid_q;
    assign o_frame_valid = frame_q;
    assign o_err         = err_q;
    assign o_err_code    = err_code_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed and randomized bench for seg7_scan_decoder; a run-length dwell model predicts
// every output each cycle.
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    i_seg;
    logic [ND-1:0] i_dig_en;
    logic [4*ND-1:0] o_digits;
    logic [ND-1:0] o_digit_valid;
    logic          o_frame_valid;
    logic          o_err;
    logic [1:0]    o_err_code;

    int tests    = 0;
    int failures = 0;
    int frames   = 0;
    int errs     = 0;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_seg         (i_seg),
        .i_dig_en      (i_dig_en),
        .o_digits      (o_digits),
        .o_digit_valid (o_digit_valid),
        .o_frame_valid (o_frame_valid),
        .o_err         (o_err),
        .o_err_code    (o_err_code)
    );

    // Reference state: the last sampled bus word, how many consecutive samples it has
    // repeated for, and the architectural outputs.
    logic [6:0]    pat_tbl [16];
    logic [3:0]    m_dig   [ND];
    logic [ND-1:0] m_dv, m_seen, m_en, m_prev_en;
    logic [6:0]    m_seg;
    logic          m_frame, m_err;
    logic [1:0]    m_code;
    int            m_run;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
        m_dv = '0; m_seen = '0; m_en = '0; m_prev_en = '0; m_seg = '0;
        m_frame = 1'b0; m_err = 1'b0; m_code = 2'b00; m_run = 1;
    endtask

    task automatic model_edge(input logic [ND-1:0] en, input logic [6:0] seg);
        int idx;
        bit ok;
        logic [3:0] val;
        m_frame = 1'b0;
        m_err   = 1'b0;
        if ($countones(m_en) == 1 && m_run == SC) begin
            idx = 0;
            for (int i = 0; i < ND; i++) if (m_en[i]) idx = i;
            ok  = 1'b0;
            val = 4'h0;
            for (int v = 0; v < 16; v++) if (pat_tbl[v] == m_seg) begin ok = 1'b1; val = 4'(v); end
            if (ok) begin
                m_dig[idx] = val;
                m_dv[idx]  = 1'b1;
                m_seen[idx] = 1'b1;
                if (&m_seen) begin m_frame = 1'b1; m_seen = '0; end
            end else begin
                m_dv[idx] = 1'b0;
                m_err = 1'b1;
                m_code = 2'b01;
            end
        end
        if ($countones(m_en) > 1 && m_en != m_prev_en) begin
            m_err = 1'b1;
            m_code = 2'b10;
        end
        if (en == m_en && seg == m_seg) m_run++;
        else m_run = 1;
        m_prev_en = m_en;
        m_en = en;
        m_seg = seg;
    endtask

    task automatic check_all(input string tag);
        logic [4*ND-1:0] ev;
        for (int i = 0; i < ND; i++) ev[4*i +: 4] = m_dig[i];
        check({tag, ".digits"}, 32'(o_digits), 32'(ev));
        check({tag, ".dvalid"}, 32'(o_digit_valid), 32'(m_dv));
        check({tag, ".frame"},  32'(o_frame_valid), 32'(m_frame));
        check({tag, ".err"},    32'(o_err), 32'(m_err));
        check({tag, ".code"},   32'(o_err_code), 32'(m_code));
    endtask

    // Called at a falling edge: drive, clock once, predict, then compare at the next falling edge.
    task automatic tick(input string tag, input logic [ND-1:0] en, input logic [6:0] seg);
        i_dig_en = en;
        i_seg    = seg;
        @(posedge clk);
        model_edge(en, seg);
        @(negedge clk);
        check_all(tag);
        frames += int'(o_frame_valid);
        errs   += int'(o_err);
    endtask

    task automatic dwell(input string tag, input logic [ND-1:0] en, input logic [6:0] seg, input int n);
        for (int k = 0; k < n; k++) tick(tag, en, seg);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".digits"}, 32'(o_digits), 32'h0);
        check({tag, ".dvalid"}, 32'(o_digit_valid), 32'h0);
        check({tag, ".frame"},  32'(o_frame_valid), 32'h0);
        check({tag, ".err"},    32'(o_err), 32'h0);
        check({tag, ".code"},   32'(o_err_code), 32'h0);
    endtask

    // Entered at a falling edge with the clock running; asserts reset between edges.
    task automatic mid_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_zero(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [ND-1:0] ren;
        logic [6:0]    rseg;
        int            rlen;

        pat_tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        model_reset();
        rst = 1'b0;
        i_seg = '0;
        i_dig_en = '0;
        #2 rst = 1'b1;
        #1 check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single digit held: capture exactly SC edges after first sample.
        dwell("hold_d2", 4'b0100, 7'b1101101, 10);
        check("hold_d2.value", 32'(o_digits[11:8]), 32'h2);

        // Full scan 7,0,b,E.
        frames = 0;
        dwell("scan", 4'b0001, 7'b1110000, 6);
        dwell("scan", 4'b0010, 7'b1111110, 6);
        dwell("scan", 4'b0100, 7'b0011111, 6);
        dwell("scan", 4'b1000, 7'b1001111, 6);
        check("scan.digits", 32'(o_digits), 32'hEB07);
        check("scan.dvalid", 32'(o_digit_valid), 32'hF);
        check("scan.frames", 32'(frames), 32'd1);

        // Short glitch on digit 1 is ignored.
        errs = 0;
        dwell("glitch", 4'b0010, 7'b0000001, 2);
        dwell("glitch", 4'b0010, 7'b0110000, 6);
        check("glitch.errs", 32'(errs), 32'd0);
        check("glitch.d1", 32'(o_digits[7:4]), 32'h1);

        // Stable but undecodable pattern on digit 0.
        errs = 0;
        dwell("badpat", 4'b0001, 7'b1010101, 6);
        check("badpat.errs", 32'(errs), 32'd1);
        check("badpat.code", 32'(o_err_code), 32'h1);
        check("badpat.dvalid", 32'(o_digit_valid), 32'hE);
        check("badpat.digits", 32'(o_digits), 32'hEB17);

        // Parked multi-hot enable.
        errs = 0;
        dwell("multi", 4'b0110, 7'b1111111, 5);
        check("multi.errs", 32'(errs), 32'd1);
        check("multi.code", 32'(o_err_code), 32'h2);
        check("multi.digits", 32'(o_digits), 32'hEB17);

        // Reset mid-dwell after a frame, then a fresh frame needs all four digits.
        dwell("pre_rst", 4'b0001, 7'b1111110, 6);
        dwell("pre_rst", 4'b0010, 7'b1111110, 6);
        dwell("pre_rst", 4'b0100, 7'b1111110, 6);
        dwell("pre_rst", 4'b1000, 7'b1111110, 6);
        dwell("pre_rst", 4'b0001, 7'b0110011, 2);
        mid_reset("midrst");
        frames = 0;
        dwell("post_rst", 4'b0001, 7'b1011011, 6);
        dwell("post_rst", 4'b0010, 7'b1011011, 6);
        dwell("post_rst", 4'b0100, 7'b1011011, 6);
        check("post_rst.partial", 32'(frames), 32'd0);
        dwell("post_rst", 4'b1000, 7'b1011011, 6);
        check("post_rst.frames", 32'(frames), 32'd1);

        // Randomized dwells: mostly one-hot and legal glyphs, with blanks, multi-hot and junk.
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 19))
                0, 1, 2:  ren = '0;
                3, 4, 5:  ren = ND'($urandom);
                default:  ren = ND'(1) << $urandom_range(0, ND - 1);
            endcase
            if ($urandom_range(0, 3) == 0) rseg = 7'($urandom);
            else rseg = pat_tbl[$urandom_range(0, 15)];
            rlen = $urandom_range(1, 8);
            dwell("rand", ren, rseg, rlen);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
